// File: rtl/ts_qos_pkg.sv
// Shared definitions for the TS quality-of-service blocks (channel monitor
// and main_control): packet geometry, sync byte, lane layout, FSM encoding.
package ts_qos_pkg;

  localparam int unsigned PKT_LEN   = 188;
  localparam logic [7:0]  SYNC_BYTE = 8'h47;
  localparam int unsigned LANE_W    = 8;
  localparam int unsigned N_LANES   = 4;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    PRESYNC = 2'd1,
    SYNC    = 2'd2
  } ts_state_e;

endpackage

// File: rtl/ts_sync_checker.sv
// One TS byte lane: sync acquisition / loss FSM, idle timeout and a
// saturating 8-bit error counter with a synchronous clear.
module ts_sync_checker #(
  parameter int unsigned PKT_LEN   = ts_qos_pkg::PKT_LEN,
  parameter logic [7:0]  SYNC_BYTE = ts_qos_pkg::SYNC_BYTE,
  parameter int unsigned LOCK_N    = 3,
  parameter int unsigned LOSS_N    = 3,
  parameter int unsigned TIMEOUT   = 1000
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [7:0] i_data,
  input  logic       i_valid,
  input  logic       i_clr,
  output logic [7:0] o_err,
  output logic       o_sync
);

  import ts_qos_pkg::*;

  localparam int unsigned POS_W  = $clog2(PKT_LEN);
  localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);
  localparam int unsigned GOOD_W = $clog2(LOCK_N + 1);
  localparam int unsigned MISS_W = $clog2(LOSS_N + 1);

  ts_state_e         r_state;
  logic [POS_W-1:0]  r_pos;
  logic [GOOD_W-1:0] r_good;
  logic [MISS_W-1:0] r_miss;
  logic [IDLE_W-1:0] r_idle;
  logic [7:0]        r_err;
  logic              r_sync;

  ts_state_e         w_state_nxt;
  logic [POS_W-1:0]  w_pos_nxt;
  logic [POS_W-1:0]  w_pos_inc;
  logic [GOOD_W-1:0] w_good_nxt;
  logic [MISS_W-1:0] w_miss_nxt;
  logic              w_err_inc;
  logic              w_drop;

  // Next-state decode: acquisition, loss, TEI detection and idle timeout.
  always_comb begin
    w_state_nxt = r_state;
    w_pos_nxt   = r_pos;
    w_good_nxt  = r_good;
    w_miss_nxt  = r_miss;
    w_err_inc   = 1'b0;
    w_drop      = 1'b0;
    w_pos_inc   = (r_pos == POS_W'(PKT_LEN - 1)) ? '0 : r_pos + 1'b1;
    if (i_valid) begin
      unique case (r_state)
        HUNT: begin
          if (i_data == SYNC_BYTE) begin
            w_state_nxt = PRESYNC;
            w_pos_nxt   = POS_W'(1);
            w_good_nxt  = GOOD_W'(1);
          end
        end
        PRESYNC: begin
          w_pos_nxt = w_pos_inc;
          if (r_pos == '0) begin
            if (i_data == SYNC_BYTE) begin
              w_good_nxt = r_good + 1'b1;
              if (w_good_nxt >= GOOD_W'(LOCK_N)) w_state_nxt = SYNC;
            end else begin
              w_drop = 1'b1;
            end
          end
        end
        SYNC: begin
          w_pos_nxt = w_pos_inc;
          if (r_pos == '0) begin
            if (i_data != SYNC_BYTE) begin
              w_err_inc  = 1'b1;
              w_miss_nxt = r_miss + 1'b1;
              if (w_miss_nxt >= MISS_W'(LOSS_N)) w_drop = 1'b1;
            end else begin
              w_miss_nxt = '0;
            end
          end else if (r_pos == POS_W'(1) && i_data[7]) begin
            w_err_inc = 1'b1;
          end
        end
        default: w_drop = 1'b1;
      endcase
    end else if (r_state != HUNT && r_idle == IDLE_W'(TIMEOUT - 1)) begin
      w_drop = 1'b1;
    end
    if (w_drop) begin
      w_state_nxt = HUNT;
      w_pos_nxt   = '0;
      w_good_nxt  = '0;
      w_miss_nxt  = '0;
    end
  end

  // State, counters and registered outputs; clear beats a same-edge increment.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= HUNT;
      r_pos   <= '0;
      r_good  <= '0;
      r_miss  <= '0;
      r_idle  <= '0;
      r_err   <= '0;
      r_sync  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pos   <= w_pos_nxt;
      r_good  <= w_good_nxt;
      r_miss  <= w_miss_nxt;
      r_sync  <= (w_state_nxt == SYNC);
      if (i_valid)                          r_idle <= '0;
      else if (r_idle != IDLE_W'(TIMEOUT))  r_idle <= r_idle + 1'b1;
      if (i_clr)                            r_err <= '0;
      else if (w_err_inc && r_err != '1)    r_err <= r_err + 1'b1;
    end
  end

  assign o_err  = r_err;
  assign o_sync = r_sync;

endmodule

// File: rtl/ts_channel_monitor.sv
// Four independent TS lane monitors; this level only splits the input lanes
// and packs the per-lane error counters and lock flags.
module ts_channel_monitor #(
  parameter int unsigned PKT_LEN   = ts_qos_pkg::PKT_LEN,
  parameter logic [7:0]  SYNC_BYTE = ts_qos_pkg::SYNC_BYTE,
  parameter int unsigned LOCK_N    = 3,
  parameter int unsigned LOSS_N    = 3,
  parameter int unsigned TIMEOUT   = 1000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] ts_data,
  input  logic [3:0]  ts_valid,
  input  logic        en_reset_counter,
  output logic [31:0] err_count,
  output logic [3:0]  sync
);

  import ts_qos_pkg::*;

  for (genvar g = 0; g < N_LANES; g++) begin : g_lane
    ts_sync_checker #(
      .PKT_LEN   (PKT_LEN),
      .SYNC_BYTE (SYNC_BYTE),
      .LOCK_N    (LOCK_N),
      .LOSS_N    (LOSS_N),
      .TIMEOUT   (TIMEOUT)
    ) u_chk (
      .clk     (clk),
      .rstn    (rstn),
      .i_data  (ts_data[g*LANE_W +: LANE_W]),
      .i_valid (ts_valid[g]),
      .i_clr   (en_reset_counter),
      .o_err   (err_count[g*LANE_W +: LANE_W]),
      .o_sync  (sync[g])
    );
  end

endmodule

// File: tb/tb_ts_channel_monitor.sv
// Bench for ts_channel_monitor: directed packet table, multi-cycle corner
// sequences, then randomized traffic, all against a behavioural lane model.
module tb_ts_channel_monitor;

  localparam int PKT  = 188;
  localparam int LOCK = 3;
  localparam int LOSS = 3;
  localparam int TO   = 1000;
  localparam logic [31:0] ALL_SYNC = 32'h4747_4747;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] ts_data;
  logic [3:0]  ts_valid;
  logic        en_reset_counter;
  logic [31:0] err_count;
  logic [3:0]  sync;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  // Behavioural lane model: locked / acquiring flags plus plain counters.
  bit m_lk [4];
  bit m_acq[4];
  int m_pos[4], m_good[4], m_miss[4], m_idle[4], m_err[4];

  typedef struct {
    logic [31:0] b0;
    logic [31:0] b1;
    logic [3:0]  exp_sync_b0;
    logic [31:0] exp_err;
  } vec_t;

  vec_t tbl[11];

  always #5 clk = ~clk;

  ts_channel_monitor dut (
    .clk              (clk),
    .rstn             (rstn),
    .ts_data          (ts_data),
    .ts_valid         (ts_valid),
    .en_reset_counter (en_reset_counter),
    .err_count        (err_count),
    .sync             (sync)
  );

  function automatic void m_drop(int c);
    m_lk[c]   = 1'b0;
    m_acq[c]  = 1'b0;
    m_pos[c]  = 0;
    m_good[c] = 0;
    m_miss[c] = 0;
  endfunction

  task automatic model_step(input bit r, input bit clr, input logic [3:0] v,
                            input logic [31:0] d);
    for (int c = 0; c < 4; c++) begin
      logic [7:0] b;
      int inc;
      bit at0, at1;
      b   = d[c*8 +: 8];
      inc = 0;
      if (r) begin
        m_drop(c);
        m_idle[c] = 0;
        m_err[c]  = 0;
      end else begin
        if (v[c]) begin
          m_idle[c] = 0;
          if (!m_lk[c] && !m_acq[c]) begin
            if (b == 8'h47) begin
              m_acq[c]  = 1'b1;
              m_pos[c]  = 1;
              m_good[c] = 1;
            end
          end else begin
            at0 = (m_pos[c] == 0);
            at1 = (m_pos[c] == 1);
            m_pos[c] = (m_pos[c] + 1) % PKT;
            if (m_acq[c]) begin
              if (at0) begin
                if (b == 8'h47) begin
                  m_good[c]++;
                  if (m_good[c] >= LOCK) begin
                    m_acq[c] = 1'b0;
                    m_lk[c]  = 1'b1;
                  end
                end else begin
                  m_drop(c);
                end
              end
            end else begin
              if (at0) begin
                if (b != 8'h47) begin
                  inc = 1;
                  m_miss[c]++;
                  if (m_miss[c] >= LOSS) m_drop(c);
                end else begin
                  m_miss[c] = 0;
                end
              end else if (at1 && b[7]) begin
                inc = 1;
              end
            end
          end
        end else begin
          if (m_idle[c] < TO) m_idle[c]++;
          if (m_idle[c] == TO) m_drop(c);
        end
        if (clr)      m_err[c] = 0;
        else if (inc != 0) m_err[c] = (m_err[c] >= 255) ? 255 : m_err[c] + 1;
      end
    end
  endtask

  function automatic logic [31:0] m_err_vec();
    logic [31:0] e;
    for (int c = 0; c < 4; c++) e[c*8 +: 8] = 8'(m_err[c]);
    return e;
  endfunction

  function automatic logic [31:0] m_sync_vec();
    logic [31:0] s;
    s = '0;
    for (int c = 0; c < 4; c++) s[c] = m_lk[c];
    return s;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock: drive, step the model at the edge, compare #1 later.
  task automatic cycle(input bit r, input bit clr, input logic [3:0] v, input logic [31:0] d);
    rstn             = ~r;
    en_reset_counter = clr;
    ts_valid         = v;
    ts_data          = d;
    @(posedge clk);
    model_step(r, clr, v, d);
    #1;
    check("model_sync", {28'b0, sync}, m_sync_vec());
    check("model_err", err_count, m_err_vec());
  endtask

  task automatic send_pkt(input logic [31:0] b0, input logic [31:0] b1, input int clr_at,
                          output logic [3:0] s0, output logic [31:0] e1);
    s0 = '0;
    e1 = '0;
    for (int i = 0; i < PKT; i++) begin
      cycle(1'b0, (i == clr_at), 4'hF, (i == 0) ? b0 : ((i == 1) ? b1 : 32'h0));
      if (i == 0) s0 = sync;
      if (i == 1) e1 = err_count;
    end
  endtask

  initial begin
    logic [3:0]  s0;
    logic [31:0] e1;
    logic [3:0]  v;
    logic [31:0] d;
    logic [7:0]  b;
    int          acc[4];

    tbl[0]  = '{ALL_SYNC,     32'h0,         4'b0000, 32'h0000_0000};
    tbl[1]  = '{ALL_SYNC,     32'h0,         4'b0000, 32'h0000_0000};
    tbl[2]  = '{ALL_SYNC,     32'h0,         4'b1111, 32'h0000_0000};
    tbl[3]  = '{ALL_SYNC,     32'h0,         4'b1111, 32'h0000_0000};
    tbl[4]  = '{ALL_SYNC,     32'h0000_8000, 4'b1111, 32'h0000_0100};
    tbl[5]  = '{32'h4700_4747, 32'h0,        4'b1111, 32'h0001_0100};
    tbl[6]  = '{32'h4700_4747, 32'h0,        4'b1111, 32'h0002_0100};
    tbl[7]  = '{32'h4700_4747, 32'h0,        4'b1011, 32'h0003_0100};
    tbl[8]  = '{32'h4747_4700, 32'h0,        4'b1011, 32'h0003_0101};
    tbl[9]  = '{ALL_SYNC,     32'h0,         4'b1011, 32'h0003_0101};
    tbl[10] = '{ALL_SYNC,     32'h0,         4'b1111, 32'h0003_0101};

    for (int c = 0; c < 4; c++) begin
      m_drop(c);
      m_idle[c] = 0;
      m_err[c]  = 0;
      acc[c]    = 0;
    end

    // Reset state
    cycle(1'b1, 1'b0, 4'h0, 32'h0);
    cycle(1'b1, 1'b0, 4'h0, 32'h0);
    check("rst_sync", {28'b0, sync}, 32'h0);
    check("rst_err", err_count, 32'h0);

    // Directed packet table: lock, TEI, sync loss, single miss recovery
    for (int i = 0; i < 11; i++) begin
      send_pkt(tbl[i].b0, tbl[i].b1, -1, s0, e1);
      check($sformatf("tbl%0d_sync", i), {28'b0, s0}, {28'b0, tbl[i].exp_sync_b0});
      check($sformatf("tbl%0d_err", i), err_count, tbl[i].exp_err);
    end

    // Saturation of ch2 and clear colliding with an increment
    repeat (254) send_pkt(ALL_SYNC, 32'h0000_8000, -1, s0, e1);
    check("sat_255", err_count, 32'h0003_FF01);
    send_pkt(ALL_SYNC, 32'h0000_8000, -1, s0, e1);
    check("sat_hold", err_count, 32'h0003_FF01);
    send_pkt(ALL_SYNC, 32'h0000_8000, 1, s0, e1);
    check("clr_collide_b1", e1, 32'h0);
    check("clr_collide_end", err_count, 32'h0);

    // Idle timeout boundary
    repeat (TO - 1) cycle(1'b0, 1'b0, 4'h0, 32'h0);
    check("idle_999_sync", {28'b0, sync}, 32'hF);
    send_pkt(ALL_SYNC, 32'h8000_0000, -1, s0, e1);
    check("tei_ch4", err_count, 32'h0100_0000);
    repeat (TO) cycle(1'b0, 1'b0, 4'h0, 32'h0);
    check("idle_1000_sync", {28'b0, sync}, 32'h0);
    check("idle_1000_err", err_count, 32'h0100_0000);

    // Relock, then reset mid-packet and relock from scratch
    for (int p = 0; p < 3; p++) begin
      send_pkt(ALL_SYNC, 32'h0, -1, s0, e1);
      check($sformatf("relock%0d", p), {28'b0, s0}, (p == 2) ? 32'hF : 32'h0);
    end
    for (int i = 0; i < 50; i++) cycle(1'b0, 1'b0, 4'hF, (i == 0) ? ALL_SYNC : 32'h0);
    cycle(1'b1, 1'b0, 4'hF, ALL_SYNC);
    check("midrst_sync", {28'b0, sync}, 32'h0);
    check("midrst_err", err_count, 32'h0);
    for (int p = 0; p < 3; p++) begin
      send_pkt(ALL_SYNC, 32'h0, -1, s0, e1);
      check($sformatf("postrst%0d", p), {28'b0, s0}, (p == 2) ? 32'hF : 32'h0);
    end

    // Randomized traffic, loosely packet-aligned per lane
    for (int k = 0; k < 8000; k++) begin
      v = '0;
      d = '0;
      for (int c = 0; c < 4; c++) begin
        v[c] = ($urandom_range(99) < 97);
        if (acc[c] % PKT == 0)      b = ($urandom_range(9) != 0) ? 8'h47 : 8'($urandom);
        else if (acc[c] % PKT == 1) b = {($urandom_range(4) == 0), 7'($urandom)};
        else                        b = 8'($urandom);
        d[c*8 +: 8] = b;
        if (v[c]) acc[c]++;
      end
      cycle(($urandom_range(3999) == 0), ($urandom_range(499) == 0), v, d);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
